// File: rtl/cpu_core_p.sv
// cpu_core_p: parametrised multi-cycle CPU core, 4 GP registers, Z/C flags, 16-op ISA
// Ports: clk; reset (async, active-low); address/data_out/read/write drive the memory bus,
//   data_in/ready return read data and completion; halted flags a HALT instruction.
module cpu_core_p #(
   parameter int WIDTH = 8,
   parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
   input  logic             clk,
   input  logic             reset,
   output logic [WIDTH-1:0] address,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out,
   input  logic             ready,
   output logic             read,
   output logic             write,
   output logic             halted
);
   typedef enum logic [2:0] {RST, FETCH, DECODE, IMM, MEM, HALT} state_t;
   state_t state, state_nx;
   logic [WIDTH-1:0] ip;
   logic [WIDTH-1:0] r [4];
   logic [7:0] ir;
   logic z, c;
   logic [3:0] op;
   logic [1:0] rd, rs;
   logic [WIDTH-1:0] a, b;
   logic [WIDTH:0] alu;
   logic is_alu, take;
   assign op = ir[7:4];
   assign rd = ir[3:2];
   assign rs = ir[1:0];
   assign a = r[rd];
   assign b = r[rs];
   assign is_alu = op >= 4'h5 && op <= 4'hA;
   assign take = op == 4'hB || (op == 4'hC && z) || (op == 4'hD && c);
   assign halted = state == HALT;
   // bit WIDTH carries the flag C: carry, borrow or the bit shifted out; MOV falls to the default
   always_comb
      alu = op == 4'h5 ? {1'b0, a} + {1'b0, b} :
            op == 4'h6 ? {1'b0, a} - {1'b0, b} :
            op == 4'h7 ? {1'b0, a & b} :
            op == 4'h8 ? {1'b0, a | b} :
            op == 4'h9 ? {1'b0, a ^ b} :
            op == 4'hA ? {a[0], 1'b0, a[WIDTH-1:1]} : {1'b0, b};
   always_comb begin
      state_nx = state;
      address = '0;
      data_out = '0;
      read = 1'b0;
      write = 1'b0;
      case (state)
         RST: state_nx = FETCH;
         FETCH, IMM: begin
            address = ip;
            read = 1'b1;
            if (ready) state_nx = state == FETCH ? DECODE : FETCH;
         end
         DECODE: state_nx = (op == 4'h1 || (op >= 4'hB && op <= 4'hD)) ? IMM :
                            (op == 4'h2 || op == 4'h3) ? MEM :
                            op == 4'hF ? HALT : FETCH;
         MEM: begin
            address = op == 4'h3 ? a : b;
            data_out = op == 4'h3 ? b : '0;
            read = op != 4'h3;
            write = op == 4'h3;
            if (ready) state_nx = FETCH;
         end
         default: ;
      endcase
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= RST;
         ip <= RESET_VECTOR;
         ir <= '0;
         z <= 1'b0;
         c <= 1'b0;
         for (int i = 0; i < 4; i++) r[i] <= '0;
      end else begin
         state <= state_nx;
         if (state == FETCH && ready) begin
            ir <= data_in[7:0];
            ip <= ip + 1'b1;
         end
         if (state == DECODE && (is_alu || op == 4'h4)) r[rd] <= alu[WIDTH-1:0];
         if (state == DECODE && is_alu) begin
            z <= alu[WIDTH-1:0] == '0;
            c <= alu[WIDTH];
         end
         // the immediate word is always consumed; a taken jump overrides the increment
         if (state == IMM && ready) begin
            ip <= take ? data_in : ip + 1'b1;
            if (op == 4'h1) r[rd] <= data_in;
         end
         if (state == MEM && ready && op == 4'h2) r[rd] <= data_in;
      end
   end
endmodule

// File: tb/tb_cpu_core_p.sv
// tb_cpu_core_p: self-checking bench for cpu_core_p at WIDTH 8 and 16
module tb_cpu_core_p;
   logic clk = 1'b0, reset = 1'b0;
   logic [7:0] addr8, dout8, din8 = '0;
   logic ready8 = 1'b1, read8, write8, halted8;
   logic [15:0] addr16, dout16, din16 = '0;
   logic ready16 = 1'b1, read16, write16, halted16;
   logic [7:0] mem8 [256];
   logic [15:0] mem16 [256];
   int rd_cyc [256];
   int checks = 0, errors = 0, cyc = 0, wstall = 0, rstall = 0;
   int nw8, nw16, w40, both = 0;
   logic [7:0] waddr8, wdata8, last_ra8;
   logic [15:0] waddr16, wdata16, last_ra16;
   typedef struct {
      string nm;
      logic [7:0] opb, a, b, res;
      bit z, c;
   } vec_t;
   vec_t tbl [14];
   int ops [9] = '{0, 4, 5, 6, 7, 8, 9, 10, 14};

   always #5 clk = ~clk;

   cpu_core_p #(.WIDTH(8), .RESET_VECTOR(8'h00)) u8 (
      .clk(clk), .reset(reset), .address(addr8), .data_in(din8), .data_out(dout8),
      .ready(ready8), .read(read8), .write(write8), .halted(halted8));
   cpu_core_p #(.WIDTH(16), .RESET_VECTOR(16'h0000)) u16 (
      .clk(clk), .reset(reset), .address(addr16), .data_in(din16), .data_out(dout16),
      .ready(ready16), .read(read16), .write(write16), .halted(halted16));

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // one clock: memory answers the address now on the bus, completed transfers are logged
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      din8 = mem8[addr8];
      din16 = mem16[addr16[7:0]];
      ready8 = 1'b1;
      if (write8 && wstall > 0) begin
         ready8 = 1'b0;
         wstall--;
      end else if (read8 && rstall > 0) begin
         ready8 = 1'b0;
         rstall--;
      end
      if (read8 && write8) both++;
      if (write8 && addr8 == 8'h40 && dout8 == 8'h5A) w40++;
      if (ready8 && write8) begin
         mem8[addr8] = dout8;
         nw8++;
         waddr8 = addr8;
         wdata8 = dout8;
      end
      if (ready8 && read8) begin
         last_ra8 = addr8;
         rd_cyc[addr8] = cyc;
      end
      if (write16) begin
         mem16[addr16[7:0]] = dout16;
         nw16++;
         waddr16 = addr16;
         wdata16 = dout16;
      end
      if (read16) last_ra16 = addr16;
   endtask

   task automatic clear_mem();
      foreach (mem8[i]) begin
         mem8[i] = '0;
         mem16[i] = '0;
      end
   endtask

   task automatic put(input int ad, input logic [15:0] v);
      mem8[ad] = v[7:0];
      mem16[ad] = v;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      wstall = 0;
      rstall = 0;
      repeat (3) tick();
      nw8 = 0;
      nw16 = 0;
      w40 = 0;
      last_ra8 = '0;
      last_ra16 = '0;
      foreach (rd_cyc[i]) rd_cyc[i] = 0;
      reset = 1'b1;
   endtask

   task automatic run(input bit wide);
      int n = 0;
      while (!(wide ? halted16 : halted8) && n < 400) begin
         tick();
         n++;
      end
      check(wide ? "halt16_reached" : "halt8_reached", {31'b0, wide ? halted16 : halted8}, 1);
   endtask

   // result of the op lands at 0x80; the Z/C branch tree leaves the core halted at a flag-specific address
   task automatic load_vec(input logic [7:0] opb, input logic [15:0] a, input logic [15:0] b);
      clear_mem();
      put(0, 16'h10); put(1, a); put(2, 16'h14); put(3, b); put(4, {8'h0, opb});
      put(5, 16'h18); put(6, 16'h80); put(7, 16'h38); put(8, 16'hC0); put(9, 16'h40);
      put(10, 16'hD0); put(11, 16'h60); put(12, 16'hF0);
      put(8'h40, 16'hD0); put(8'h41, 16'h70); put(8'h42, 16'hF0);
      put(8'h60, 16'hF0); put(8'h70, 16'hF0);
   endtask

   function automatic logic [15:0] haddr(input bit z, input bit c);
      return z ? (c ? 16'h70 : 16'h42) : (c ? 16'h60 : 16'h0C);
   endfunction

   task automatic run_vec(input string nm, input logic [7:0] opb, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] res, input bit z, input bit c,
                          input bit wide, input logic [15:0] w0);
      load_vec(opb, a, b);
      put(0, w0);
      do_reset();
      run(wide);
      check({nm, "_nwrites"}, wide ? nw16 : nw8, 1);
      check({nm, "_waddr"}, wide ? {16'h0, waddr16} : {24'h0, waddr8}, 32'h80);
      check({nm, "_result"}, wide ? {16'h0, wdata16} : {24'h0, wdata8}, {16'h0, res});
      check({nm, "_flags_zc"}, wide ? {16'h0, last_ra16} : {24'h0, last_ra8}, {16'h0, haddr(z, c)});
   endtask

   // reference: instruction semantics in plain integer arithmetic, r0 op rs with r0=a, r1=b, r2=r3=0
   function automatic void model(input int w, input logic [7:0] opb, input int a, input int b,
                                 output int res, output bit z, output bit c);
      int op, y, m;
      op = int'(opb[7:4]);
      m = 1 << w;
      y = opb[1:0] == 2'd1 ? b : opb[1:0] == 2'd0 ? a : 0;
      res = a;
      z = 1'b0;
      c = 1'b0;
      case (op)
         4: res = y;
         5: begin res = (a + y) % m; c = (a + y) >= m; end
         6: begin res = (a - y + m) % m; c = a < y; end
         7: res = a & y;
         8: res = a | y;
         9: res = a ^ y;
         10: begin res = a / 2; c = (a % 2) == 1; end
         default: ;
      endcase
      if (op >= 5 && op <= 10) z = res == 0;
   endfunction

   initial begin
      int rop, rrs, ra, rb, rres, base, act;
      bit rz, rc;
      logic [7:0] ropb;
      tbl[0]  = '{"add_ff_01",  8'h51, 8'hFF, 8'h01, 8'h00, 1, 1};
      tbl[1]  = '{"sub_00_01",  8'h61, 8'h00, 8'h01, 8'hFF, 0, 1};
      tbl[2]  = '{"sub_05_03",  8'h61, 8'h05, 8'h03, 8'h02, 0, 0};
      tbl[3]  = '{"sub_same",   8'h60, 8'h37, 8'h00, 8'h00, 1, 0};
      tbl[4]  = '{"and_f0_3c",  8'h71, 8'hF0, 8'h3C, 8'h30, 0, 0};
      tbl[5]  = '{"and_zero",   8'h71, 8'h0F, 8'hF0, 8'h00, 1, 0};
      tbl[6]  = '{"or_12_21",   8'h81, 8'h12, 8'h21, 8'h33, 0, 0};
      tbl[7]  = '{"xor_same",   8'h91, 8'hAA, 8'hAA, 8'h00, 1, 0};
      tbl[8]  = '{"shr_03",     8'hA0, 8'h03, 8'h00, 8'h01, 0, 1};
      tbl[9]  = '{"shr_01",     8'hA0, 8'h01, 8'h00, 8'h00, 1, 1};
      tbl[10] = '{"mov",        8'h41, 8'h11, 8'h99, 8'h99, 0, 0};
      tbl[11] = '{"nop",        8'h00, 8'h42, 8'h10, 8'h42, 0, 0};
      tbl[12] = '{"reserved_e", 8'hE5, 8'h07, 8'h10, 8'h07, 0, 0};
      tbl[13] = '{"add_nocarry",8'h51, 8'h80, 8'h7F, 8'hFF, 0, 0};

      clear_mem();
      reset = 1'b0;
      repeat (3) tick();
      check("rst_read", {31'b0, read8}, 0);
      check("rst_write", {31'b0, write8}, 0);
      check("rst_halted", {31'b0, halted8}, 0);
      check("rst_address", {24'h0, addr8}, 0);
      check("rst_data_out", {24'h0, dout8}, 0);
      reset = 1'b1;
      check("rel_cycle1_read", {31'b0, read8}, 0);
      tick();
      check("rel_cycle2_read", {31'b0, read8}, 1);
      check("rel_cycle2_address", {24'h0, addr8}, 0);

      for (int i = 0; i < 14; i++)
         run_vec(tbl[i].nm, tbl[i].opb, {8'h0, tbl[i].a}, {8'h0, tbl[i].b}, {8'h0, tbl[i].res},
                 tbl[i].z, tbl[i].c, 1'b0, 16'h0010);

      for (int k = 0; k < 30; k++) begin
         rop = ops[$urandom_range(0, 8)];
         rrs = $urandom_range(0, 3);
         ra = $urandom_range(0, 255);
         rb = $urandom_range(0, 255);
         ropb = 8'((rop << 4) | rrs);
         model(8, ropb, ra, rb, rres, rz, rc);
         run_vec("rand", ropb, 16'(ra), 16'(rb), 16'(rres), rz, rc, 1'b0, 16'h0010);
      end

      run_vec("w16_add_ffff", 8'h50, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, 1'b1, 1'b1, 16'hAB10);

      clear_mem();
      put(0, 16'h18); put(1, 16'h40); put(2, 16'h1C); put(3, 16'h5A); put(4, 16'h3B);
      put(5, 16'h22); put(6, 16'h14); put(7, 16'h90); put(8, 16'h34); put(9, 16'h3A); put(10, 16'hF0);
      do_reset();
      wstall = 3;
      run(1'b0);
      check("st_held_cycles", w40, 4);
      check("st_instr_cycles", rd_cyc[5] - rd_cyc[4], 6);
      check("ld_value", {24'h0, mem8[8'h90]}, 32'h5A);
      check("st_rd_eq_rs", {24'h0, mem8[8'h40]}, 32'h40);

      for (int v = 0; v < 2; v++) begin
         clear_mem();
         put(0, 16'h10); put(1, 16'h01); put(2, 16'h14); put(3, 16'h01);
         put(4, v == 0 ? 16'h61 : 16'h51);
         put(5, 16'hC0); put(6, 16'h20); put(7, 16'hF0); put(8'h20, 16'hF0);
         do_reset();
         run(1'b0);
         check(v == 0 ? "jz_taken" : "jz_not_taken", {24'h0, last_ra8}, v == 0 ? 32'h20 : 32'h07);
      end

      for (int v = 0; v < 2; v++) begin
         clear_mem();
         put(0, 16'hD0); put(1, 16'h40); put(2, 16'h10); put(3, 16'hFF); put(4, 16'h50);
         put(5, 16'hB0); put(6, 16'hFE); put(8'h40, 16'hF0);
         put(8'hFE, v == 0 ? 16'hB0 : 16'h00);
         do_reset();
         run(1'b0);
         check(v == 0 ? "jmp_at_fe" : "ip_wrap", {24'h0, last_ra8}, 32'h40);
         if (v == 0) check("jmp_imm_read_ff", {31'b0, rd_cyc[255] > rd_cyc[254]}, 1);
      end

      clear_mem();
      put(0, 16'h00); put(1, 16'h10); put(2, 16'h05); put(3, 16'h41); put(4, 16'hF0);
      do_reset();
      run(1'b0);
      check("lat_nop", rd_cyc[1] - rd_cyc[0], 2);
      check("lat_ldi", rd_cyc[3] - rd_cyc[1], 3);
      check("lat_mov", rd_cyc[4] - rd_cyc[3], 2);

      clear_mem();
      put(0, 16'hF0);
      do_reset();
      run(1'b0);
      act = 0;
      repeat (20) begin
         tick();
         if (read8 || write8 || !halted8) act++;
      end
      check("halt_idle", act, 0);

      clear_mem();
      do_reset();
      repeat (5) tick();
      rstall = 10;
      repeat (2) tick();
      check("fetch_stall_read", {31'b0, read8}, 1);
      check("fetch_stall_addr", {24'h0, addr8}, 3);
      reset = 1'b0;
      #1;
      check("async_read_drop", {31'b0, read8}, 0);
      check("async_addr_zero", {24'h0, addr8}, 0);
      base = cyc;
      tick();
      rstall = 0;
      reset = 1'b1;
      tick();
      check("refetch_read", {31'b0, read8}, 1);
      check("refetch_addr", {24'h0, addr8}, 0);
      check("refetch_cycles", cyc - base, 2);

      check("rw_exclusive", both, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
